store_buffer: RTL and testbench
===============================

# store_buffer

Committed-store queue sitting directly downstream of commit. Accepts one committed store request per cycle on the commit-side push port, holds up to DEPTH entries in program order, and drains them one at a time to the data-memory port with a valid/ready handshake. Also answers same-cycle load address lookups so the load path can stall on, or forward from, committed stores that have not reached memory.

## Interface
- DEPTH, 4: entry count; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- store_memreq  in  data_memreq_t  committed store; uses .addr, .wdata, .byteenable; stored unchanged.
- store_push  in  1  enqueue store_memreq this cycle.
- store_full  out  1  count == DEPTH.
- empty  out  1  count == 0; used to drain before SYNC/CACHE.
- mem_req  out  data_memreq_t  head entry, unchanged.
- mem_req_valid  out  1  head entry valid (= ~empty).
- mem_req_ready  in  1  data memory accepts mem_req this cycle.
- lookup_addr  in  32  load address to check.
- lookup_hit  out  1  some valid entry has addr[31:2] == lookup_addr[31:2].
- lookup_data  out  32  forwarded bytes; STORE_BUF_FWD_EN only.
- lookup_be  out  4  bytes covered by lookup_data; STORE_BUF_FWD_EN only.

## Operation
- Circular FIFO: entries array, head and tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: store_push & ~store_full writes the entry at tail, then tail++. store_push while store_full is ignored, with no state change. Commit already gates push with full.
- Pop: mem_req_valid & mem_req_ready advances head++. mem_req and mem_req_valid stay stable until the handshake completes.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, the push is still rejected, because full is evaluated on the current count.
- No flush input. Committed stores are never discarded; only reset clears the queue.
- Lookup is combinational and uses registered entries only:
  - A push in the same cycle is not visible to lookup.
  - An entry popping in the same cycle is still visible.
- Forwarding merge: for each byte lane, take the youngest matching entry whose byteenable covers that lane. lookup_be is the OR of covered lanes.

## Timing
- Reset values: head = tail = count = 0; store_full = 0; empty = 1; mem_req_valid = 0; lookup_hit = 0; lookup_data = 0; lookup_be = 0. Entry contents are cleared to 0.
- Push to memory latency: a push in cycle N into an empty buffer gives mem_req_valid = 1 in cycle N+1.
- Throughput: one push and one pop per cycle.
- store_full, empty and mem_req_valid are driven from registers; there is no combinational path from store_push or mem_req_ready.
- lookup_* are combinational from lookup_addr.
- Reset asserted mid-operation, including during a pending mem_req, empties the queue immediately. mem_req_valid drops asynchronously.

## Configuration
- STORE_BUF_FWD_EN defined: lookup_data and lookup_be carry the per-byte youngest-first merge.
- STORE_BUF_FWD_EN undefined:
  - lookup_data and lookup_be are tied to 0 and no merge logic is built.
  - lookup_hit behaves identically; the load path must stall on a hit until the store drains.

## Test plan
- Reset, then push addr 0x80001000, wdata 0xDEADBEEF, be 4'b1111 with mem_req_ready = 0 -> next cycle mem_req_valid = 1, mem_req.addr = 0x80001000. Holding ready = 0 for 3 cycles keeps mem_req unchanged. Ready = 1 -> empty = 1 the following cycle.
- DEPTH = 4, ready = 0, push 4 stores -> store_full = 1. A 5th push is ignored. Then drain with ready = 1 -> 4 requests in push order, and wrap-around is exercised by 4 further pushes.
- Full buffer with simultaneous push and pop -> pop occurs, push rejected, count = 3, store_full = 0 next cycle.
- Push be 4'b0011 data 0x0000AAAA, then be 4'b0110 data 0x00BBBB00, both to 0x1004. Lookup 0x1006 -> lookup_hit = 1, lookup_data = 0x00BBBBAA, lookup_be = 4'b0111 (with STORE_BUF_FWD_EN); data and be = 0 without it.
- Lookup 0x1008 with only 0x1004 stored -> lookup_hit = 0. A push to 0x1008 in the same cycle still gives hit = 0; the next cycle gives hit = 1.
- Assert rst low with 3 entries pending and mem_req_valid = 1 -> mem_req_valid = 0 and empty = 1 immediately. After release, no stale request is issued.

Source files
------------

// File: rtl/store_buffer_if.sv
// Request type and port bundle for store_buffer: the commit push side, the memory drain side and the load lookup.
typedef struct packed {
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteenable;
} data_memreq_t;

interface store_buffer_if;
  data_memreq_t store_memreq;
  logic         store_push;
  logic         store_full;
  logic         empty;
  data_memreq_t mem_req;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [31:0]  lookup_data;
  logic [3:0]   lookup_be;

  modport master (
    output store_memreq, store_push, mem_req_ready, lookup_addr,
    input  store_full, empty, mem_req, mem_req_valid, lookup_hit, lookup_data, lookup_be
  );

  modport slave (
    input  store_memreq, store_push, mem_req_ready, lookup_addr,
    output store_full, empty, mem_req, mem_req_valid, lookup_hit, lookup_data, lookup_be
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order committed-store FIFO draining to data memory, with a same-cycle load lookup.
// Define STORE_BUF_FWD_EN to build the per-byte youngest-first forwarding merge on lookup_data/lookup_be.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  data_memreq_t     r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [DEPTH-1:0] w_match;
  logic             w_unused;

  assign w_push = bus.store_push & ~r_full;
  assign w_pop  = ~r_empty & bus.mem_req_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // Full/empty are registered from the next count so the handshake outputs have no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_entries[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_entries[r_tail] <= bus.store_memreq;
        r_tail            <= r_tail + PTR_W'(1);
      end
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign bus.store_full    = r_full;
  assign bus.empty         = r_empty;
  assign bus.mem_req       = r_entries[r_head];
  assign bus.mem_req_valid = ~r_empty;

  // w_match is indexed by age: bit 0 is the head (oldest) entry.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < DEPTH; k++)
      w_match[k] = (CNT_W'(k) < r_count) &&
                   (r_entries[r_head + PTR_W'(k)].addr[31:2] == bus.lookup_addr[31:2]);
  end

  assign bus.lookup_hit = |w_match;
  assign w_unused       = ^bus.lookup_addr[1:0];

`ifdef STORE_BUF_FWD_EN
  logic [31:0] w_fwd_data;
  logic [3:0]  w_fwd_be;

  // Walk oldest to youngest so a younger covering store overwrites each lane.
  always_comb begin
    w_fwd_data = '0;
    w_fwd_be   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_match[k] && r_entries[r_head + PTR_W'(k)].byteenable[b]) begin
          w_fwd_data[8*b +: 8] = r_entries[r_head + PTR_W'(k)].wdata[8*b +: 8];
          w_fwd_be[b]          = 1'b1;
        end
      end
    end
  end

  assign bus.lookup_data = w_fwd_data;
  assign bus.lookup_be   = w_fwd_be;
`else
  assign bus.lookup_data = '0;
  assign bus.lookup_be   = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences and a randomized run against a queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  data_memreq_t q[$];
  int n_pass;
  int n_total;

  typedef struct {
    logic        push;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        exp_valid;
    logic        exp_full;
    logic        exp_empty;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic p, logic [31:0] a, logic r, logic v, logic f, logic e, logic [31:0] ea);
    vec_t t;
    t.push = p; t.addr = a; t.wdata = a ^ 32'h5A5A0000; t.ready = r;
    t.exp_valid = v; t.exp_full = f; t.exp_empty = e; t.exp_addr = ea;
    return t;
  endfunction

  function automatic logic [31:0] aa(int i);
    return 32'h8000_2000 + 32'(i * 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    bus.store_push    = 1'b0;
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic drive_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.store_push              = 1'b1;
    bus.store_memreq.addr       = a;
    bus.store_memreq.wdata      = d;
    bus.store_memreq.byteenable = be;
  endtask

  // Advance one clock and apply the same push/pop decision to the model queue.
  task automatic cycle();
    bit do_pop;
    bit do_push;
    do_pop  = (q.size() > 0) && (bus.mem_req_ready === 1'b1);
    do_push = (bus.store_push === 1'b1) && (q.size() < DEPTH);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(bus.store_memreq);
    #1;
  endtask

  task automatic model_lookup(input logic [31:0] a, output logic hit, output logic [31:0] d, output logic [3:0] be);
    hit = 1'b0; d = '0; be = '0;
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) hit = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr[31:2] == a[31:2] && q[i].byteenable[b]) begin
          d[8*b +: 8] = q[i].wdata[8*b +: 8];
          be[b] = 1'b1;
          break;
        end
      end
    end
    if (!FWD) begin d = '0; be = '0; end
  endtask

  task automatic check_model();
    logic        h;
    logic [31:0] d;
    logic [3:0]  be;
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.store_full), 32'(q.size() == DEPTH));
    chk("valid", 32'(bus.mem_req_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("req_addr", bus.mem_req.addr, q[0].addr);
      chk("req_wdata", bus.mem_req.wdata, q[0].wdata);
      chk("req_be", 32'(bus.mem_req.byteenable), 32'(q[0].byteenable));
    end
    model_lookup(bus.lookup_addr, h, d, be);
    chk("lookup_hit", 32'(bus.lookup_hit), 32'(h));
    chk("lookup_data", bus.lookup_data, d);
    chk("lookup_be", 32'(bus.lookup_be), 32'(be));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.store_memreq = '0;
    bus.lookup_addr  = '0;
    do_reset();

    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.store_full), 32'd0);
    chk("rst_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_hit", 32'(bus.lookup_hit), 32'd0);
    chk("rst_ldata", bus.lookup_data, 32'd0);
    chk("rst_lbe", 32'(bus.lookup_be), 32'd0);

    // Single push, held request, then drain.
    drive_push(32'h8000_1000, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    idle();
    chk("lat_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("lat_addr", bus.mem_req.addr, 32'h8000_1000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_addr", bus.mem_req.addr, 32'h8000_1000);
      chk("hold_wdata", bus.mem_req.wdata, 32'hDEAD_BEEF);
      chk("hold_valid", 32'(bus.mem_req_valid), 32'd1);
    end
    bus.mem_req_ready = 1'b1;
    cycle();
    idle();
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_valid", 32'(bus.mem_req_valid), 32'd0);

    // Fill, overflow, full push+pop, drain, and wrap.
    tbl[0]  = mk(1, aa(0),  0, 1, 0, 0, aa(0));
    tbl[1]  = mk(1, aa(1),  0, 1, 0, 0, aa(0));
    tbl[2]  = mk(1, aa(2),  0, 1, 0, 0, aa(0));
    tbl[3]  = mk(1, aa(3),  0, 1, 1, 0, aa(0));
    tbl[4]  = mk(1, aa(4),  0, 1, 1, 0, aa(0));
    tbl[5]  = mk(1, aa(5),  1, 1, 0, 0, aa(1));
    tbl[6]  = mk(0, aa(6),  1, 1, 0, 0, aa(2));
    tbl[7]  = mk(0, aa(6),  1, 1, 0, 0, aa(3));
    tbl[8]  = mk(0, aa(6),  1, 0, 0, 1, 32'h0);
    tbl[9]  = mk(1, aa(8),  0, 1, 0, 0, aa(8));
    tbl[10] = mk(1, aa(9),  0, 1, 0, 0, aa(8));
    tbl[11] = mk(1, aa(10), 0, 1, 0, 0, aa(8));
    tbl[12] = mk(1, aa(11), 0, 1, 1, 0, aa(8));
    tbl[13] = mk(0, aa(12), 1, 1, 0, 0, aa(9));
    tbl[14] = mk(0, aa(12), 1, 1, 0, 0, aa(10));
    tbl[15] = mk(0, aa(12), 1, 1, 0, 0, aa(11));
    tbl[16] = mk(0, aa(12), 1, 0, 0, 1, 32'h0);
    for (int i = 0; i < 17; i++) begin
      bus.store_push              = tbl[i].push;
      bus.store_memreq.addr       = tbl[i].addr;
      bus.store_memreq.wdata      = tbl[i].wdata;
      bus.store_memreq.byteenable = 4'b1111;
      bus.mem_req_ready           = tbl[i].ready;
      cycle();
      idle();
      chk("tbl_valid", 32'(bus.mem_req_valid), 32'(tbl[i].exp_valid));
      chk("tbl_full", 32'(bus.store_full), 32'(tbl[i].exp_full));
      chk("tbl_empty", 32'(bus.empty), 32'(tbl[i].exp_empty));
      if (tbl[i].exp_valid) begin
        chk("tbl_addr", bus.mem_req.addr, tbl[i].exp_addr);
        chk("tbl_wdata", bus.mem_req.wdata, tbl[i].exp_addr ^ 32'h5A5A0000);
      end
    end

    // Forwarding merge and same-cycle push invisibility.
    do_reset();
    drive_push(32'h0000_1004, 32'h0000_AAAA, 4'b0011);
    cycle();
    drive_push(32'h0000_1004, 32'h00BB_BB00, 4'b0110);
    cycle();
    idle();
    bus.lookup_addr = 32'h0000_1006;
    #1;
    chk("fwd_hit", 32'(bus.lookup_hit), 32'd1);
    chk("fwd_data", bus.lookup_data, FWD ? 32'h00BB_BBAA : 32'h0);
    chk("fwd_be", 32'(bus.lookup_be), FWD ? 32'h7 : 32'h0);
    bus.lookup_addr = 32'h0000_1008;
    #1;
    chk("miss_hit", 32'(bus.lookup_hit), 32'd0);
    drive_push(32'h0000_1008, 32'h1234_5678, 4'b1111);
    #1;
    chk("samecyc_hit", 32'(bus.lookup_hit), 32'd0);
    cycle();
    idle();
    chk("nextcyc_hit", 32'(bus.lookup_hit), 32'd1);
    check_model();

    // Asynchronous reset with three entries pending.
    chk("pre_rst_valid", 32'(bus.mem_req_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_hit", 32'(bus.lookup_hit), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_valid", 32'(bus.mem_req_valid), 32'd0);
    end
    idle();

    // Randomized traffic against the queue model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      bus.store_push              = ($urandom_range(0, 99) < 55);
      bus.store_memreq.addr       = 32'h2000 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      bus.store_memreq.wdata      = $urandom;
      bus.store_memreq.byteenable = 4'($urandom_range(0, 15));
      bus.mem_req_ready           = ($urandom_range(0, 99) < 45);
      bus.lookup_addr             = 32'h2000 + (32'($urandom_range(0, 4)) << 2) + 32'($urandom_range(0, 3));
      #1;
      check_model();
      cycle();
    end
    idle();
    #1;
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
